// File: rtl/demux4_pkg.sv
// Shared types and constants for the 1-to-4 demultiplexer/collector.
package demux4_pkg;
    typedef enum logic {FILL, FULL} state_t;

    localparam int         LANES     = 4;
    localparam logic [3:0] ALL_VALID = 4'b1111;
endpackage

// File: rtl/demux4_lane.sv
// One held output lane: N-bit data register with load enable plus its filled flag.
module demux4_lane #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         valid_o
);
    logic [N-1:0] data_q;
    logic         valid_q;

    // An ack clears only the filled flag; the data stays visible to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= d_i;
            valid_q <= 1'b1;
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/demux4_collect.sv
// Sequential 1-to-4 demux: steers handshaked words into four held lanes and
// flags a complete frame, stalling the source until the consumer acknowledges.
module demux4_collect
    import demux4_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         auto,
    input  logic [1:0]   sel,
    input  logic         frame_ack,
    output logic [N-1:0] out0,
    output logic [N-1:0] out1,
    output logic [N-1:0] out2,
    output logic [N-1:0] out3,
    output logic [3:0]   out_valid,
    output logic         frame_done
);
    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         frame_done_q, frame_done_d;
    logic         accept;
    logic [1:0]   lane_idx;
    logic [3:0]   load_vec;
    logic [3:0]   valid_next;
    logic [N-1:0] lane_data [LANES];

    assign in_ready   = rst_n && (state_q == FILL) && !frame_ack;
    assign accept     = in_valid && in_ready;
    assign lane_idx   = auto ? ptr_q : sel;
    assign load_vec   = accept ? (4'b0001 << lane_idx) : 4'b0000;
    assign valid_next = out_valid | load_vec;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        if (frame_ack) begin
            state_d = FILL;
            ptr_d   = 2'd0;
        end else if (accept) begin
            if (auto)
                ptr_d = ptr_q + 2'd1;
            // Completion depends only on the filled flags, whatever mode filled them.
            if (valid_next == ALL_VALID) begin
                state_d      = FULL;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            ptr_q        <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux4_lane #(.N(N)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load_vec[k]),
            .clr_i   (frame_ack),
            .d_i     (in),
            .q_o     (lane_data[k]),
            .valid_o (out_valid[k])
        );
    end

    assign out0       = lane_data[0];
    assign out1       = lane_data[1];
    assign out2       = lane_data[2];
    assign out3       = lane_data[3];
    assign frame_done = frame_done_q;
endmodule

// File: doc/demux4_collect.md
# demux4_collect

Sequential 1-to-4 demultiplexer and collector. It accepts a stream of N-bit words over a valid/ready handshake and steers each word into one of four held output registers. Lanes are chosen either round-robin or by an explicit select. The block is the write-side counterpart of the 4:1 selection path: it fills four lanes, flags a complete frame, and holds off the source until the consumer acknowledges.

## Interface
Parameters:
- N, 4, word width of input and of each output lane.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  N  data word from the source.
- in_valid  input  1  source has a word on `in`.
- in_ready  output  1  block will accept a word this cycle.
- auto  input  1  1 = round-robin lane pointer; 0 = lane taken from `sel`.
- sel  input  2  explicit lane index, used when auto = 0.
- frame_ack  input  1  consumer acknowledge; clears the frame.
- out0, out1, out2, out3  output  N  held lane registers.
- out_valid  output  4  per-lane filled flag; bit k belongs to outk.
- frame_done  output  1  one-cycle pulse when all four lanes become valid.

## Operation
- States: FILL and FULL. Reset state is FILL.
- Accept: a word is accepted on a rising edge when in_valid && in_ready.
- Lane index: in auto mode the lane is the internal 2-bit pointer `ptr`; otherwise it is `sel`.
- On accept:
  - The chosen outk is loaded with `in`.
  - out_valid[k] is set to 1.
  - In auto mode, ptr increments (3 wraps to 0).
- Explicit overwrite: writing a lane that is already valid overwrites its data. out_valid does not change.
- FILL -> FULL: on the edge where out_valid would become 4'b1111. frame_done is 1 for exactly the following cycle.
- FULL: in_ready = 0.
- frame_ack in FULL:
  - On the next edge out_valid becomes 0 and ptr becomes 0.
  - The state returns to FILL.
  - out0..out3 keep their data.
- frame_ack in FILL: aborts the partial frame with the same clears. No word is accepted that cycle.
- in_ready = rst_n && (state == FILL) && !frame_ack. It is combinational, so frame_ack takes priority over any simultaneous in_valid.
- A change of `auto` mid-frame is legal:
  - ptr is not reset by the change.
  - out_valid continues accumulating.
  - Completion is judged only on out_valid.
- Reset values: out0..out3 = 0, out_valid = 0, frame_done = 0, ptr = 0, state = FILL. in_ready is 0 while rst_n = 0.

## Timing
- Latency: a word accepted at edge t appears on outk and out_valid[k] after edge t. Throughput is one word per cycle.
- frame_done: registered. It is high for the single cycle after the fourth distinct lane fills and never stays high two cycles in a row.
- Earliest re-fill: frame_ack sampled at edge t returns the block to FILL after t. in_ready rises after t, provided frame_ack has already dropped.
- A frame in auto mode takes a minimum of 4 cycles, plus 1 ack cycle.
- Asynchronous reset mid-frame discards all partial state immediately. The first accept after release goes to lane 0 in auto mode.
- in_valid with in_ready = 0 has no effect. The source must hold `in` until it is accepted.

## Structure
- Package demux4_pkg:
  - typedef enum logic {FILL, FULL} state_t.
  - localparam LANES = 4.
  - localparam logic [3:0] ALL_VALID = 4'b1111.
- One natural sub-module: demux4_lane. It holds one N-bit register with load-enable and its valid flag, with asynchronous clear and synchronous clear on ack. It is instantiated four times under a generate loop.
- The top level holds the state register, ptr, the lane decode, and the frame_done flop.

## Test plan
- Reset then auto = 1: push 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles -> out0..out3 = 1,2,3,4; out_valid 0001, 0011, 0111, 1111; one frame_done pulse; in_ready = 0 afterwards.
- In FULL, hold in_valid = 1 with in = 4'hF for 3 cycles -> outputs unchanged. Then pulse frame_ack -> out_valid = 0, data retained, next word 4'hA lands in out0.
- auto = 0: write sel = 2 (4'h5), then sel = 2 (4'h6), then sel = 0, 1, 3 -> out2 = 6; frame_done fires only on the fourth distinct lane.
- Partial frame of two words, then frame_ack with in_valid = 1 in the same cycle -> in_ready = 0, word dropped, out_valid = 0, ptr = 0.
- Assert rst_n = 0 mid-frame (out_valid = 0011) between clock edges -> all outputs 0 immediately. After release, the first auto word goes to out0.
- N = 8 instance: push 8'hA5, 8'h5A, 8'hFF, 8'h00 -> full-width data preserved on every lane.
